// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, datapath
// select values, FSM states and the packed control word.
package mips_pkg;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_BEQ, S_ADDIEX, S_ADDIWB, S_JMP, S_HALT
  } ctrl_state_t;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       halted;
  } ctrl_word_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state -> control word decode. Only FETCH looks at mem_ready
// (IRWrite/PCWrite fire in the completing cycle); everything else is Moore.
module mips_ctrl_outdec
  import mips_pkg::*;
(
  input  ctrl_state_t state,
  input  logic        mem_ready,
  output ctrl_word_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMMSH2;
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.branch    = 1'b1;
        ctrl.pc_src    = PCSRC_ALUOUT;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_JMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
      end
      S_HALT: ctrl.halted = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM with memory wait states, halt/run control
// and a retired-instruction counter.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int OP_W  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  opcode,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             mem_req,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             Branch,
  output logic [1:0]       PCSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             halted,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_retired
);

  ctrl_state_t      state, next;
  ctrl_word_t       dec, ctrl;
  logic             retire, illegal;
  logic [CNT_W-1:0] count;

  mips_ctrl_outdec u_outdec (
    .state     (state),
    .mem_ready (mem_ready),
    .ctrl      (dec)
  );

  always_comb begin
    next    = state;
    retire  = 1'b0;
    illegal = 1'b0;
    unique case (state)
      S_FETCH:  if (mem_ready) next = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_RTYPE:     next = S_EXEC;
          OP_LW, OP_SW: next = S_MEMADR;
          OP_BEQ:       next = S_BEQ;
          OP_ADDI:      next = S_ADDIEX;
          OP_J:         next = S_JMP;
          default: begin
            next    = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) next = S_MEMWB;
      S_MEMWR:  retire = mem_ready;
      S_EXEC:   next = S_ALUWB;
      S_ADDIEX: next = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BEQ, S_ADDIWB, S_JMP: retire = 1'b1;
      S_HALT:   if (!halt_req) next = S_FETCH;
      default:  next = S_FETCH;
    endcase
    // halt_req only matters on the instruction's final cycle
    if (retire) next = halt_req ? S_HALT : S_FETCH;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      count <= '0;
    end else begin
      state <= next;
      if (retire) count <= count + CNT_W'(1);
    end
  end

  // Every output is forced low while reset is asserted, counter included.
  assign ctrl          = reset ? '0 : dec;
  assign illegal_op    = illegal & ~reset;
  assign instr_retired = reset ? '0 : count;

  assign mem_req  = ctrl.mem_req;
  assign IorD     = ctrl.iord;
  assign MemWrite = ctrl.mem_write;
  assign IRWrite  = ctrl.ir_write;
  assign PCWrite  = ctrl.pc_write;
  assign Branch   = ctrl.branch;
  assign PCSrc    = ctrl.pc_src;
  assign ALUSrcA  = ctrl.alu_src_a;
  assign ALUSrcB  = ctrl.alu_src_b;
  assign ALUOp    = ctrl.alu_op;
  assign RegDst   = ctrl.reg_dst;
  assign MemtoReg = ctrl.mem_to_reg;
  assign RegWrite = ctrl.reg_write;
  assign halted   = ctrl.halted;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: each stimulus cycle pushes the
// expected control word and counter; a negedge monitor pops and compares.
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = '0;
  logic        mem_ready = 1'b0;
  logic        halt_req = 1'b0;
  logic        mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch;
  logic [1:0]  PCSrc, ALUSrcB, ALUOp;
  logic        ALUSrcA, RegDst, MemtoReg, RegWrite, halted, illegal_op;
  logic [31:0] instr_retired;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.CNT_W(32), .OP_W(6)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .halt_req(halt_req), .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch), .PCSrc(PCSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .halted(halted),
    .illegal_op(illegal_op), .instr_retired(instr_retired)
  );

  typedef enum int {
    T_RST, T_FETCH, T_DEC, T_DECI, T_MEMADR, T_MEMRD, T_MEMWB, T_MEMWR,
    T_EXEC, T_ALUWB, T_BEQ, T_ADDIEX, T_ADDIWB, T_JMP, T_HALT
  } tst_t;

  typedef struct {
    logic [18:0] w;
    logic [31:0] c;
    int          id;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          step_id = 0;
  logic [31:0] cnt_exp = '0;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BQ = 6'b000100, AI = 6'b001000, JP = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  // Word order: mem_req IorD MemWrite IRWrite PCWrite Branch PCSrc ALUSrcA
  // ALUSrcB ALUOp RegDst MemtoReg RegWrite halted illegal_op
  function automatic logic [18:0] model(tst_t s, logic rdy);
    logic mr, io, mw, irw, pcw, br, sa, rd, m2r, rw, h, il;
    logic [1:0] ps, sb_, ao;
    {mr, io, mw, irw, pcw, br, sa, rd, m2r, rw, h, il} = '0;
    ps = 2'b00; sb_ = 2'b00; ao = 2'b00;
    case (s)
      T_FETCH:  begin mr = 1; sb_ = 2'b01; irw = rdy; pcw = rdy; end
      T_DEC:    sb_ = 2'b11;
      T_DECI:   begin sb_ = 2'b11; il = 1; end
      T_MEMADR: begin sa = 1; sb_ = 2'b10; end
      T_MEMRD:  begin mr = 1; io = 1; end
      T_MEMWB:  begin rw = 1; m2r = 1; end
      T_MEMWR:  begin mr = 1; io = 1; mw = 1; end
      T_EXEC:   begin sa = 1; ao = 2'b10; end
      T_ALUWB:  begin rw = 1; rd = 1; end
      T_BEQ:    begin sa = 1; ao = 2'b01; br = 1; ps = 2'b01; end
      T_ADDIEX: begin sa = 1; sb_ = 2'b10; end
      T_ADDIWB: rw = 1;
      T_JMP:    begin pcw = 1; ps = 2'b10; end
      T_HALT:   h = 1;
      default:  ;
    endcase
    return {mr, io, mw, irw, pcw, br, ps, sa, sb_, ao, rd, m2r, rw, h, il};
  endfunction

  task automatic step(tst_t s, logic [5:0] op, logic rdy, logic hlt, logic rst);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; opcode = op; mem_ready = rdy; halt_req = hlt;
    if (rst) cnt_exp = '0;
    e.w = model(s, rdy);
    e.c = cnt_exp;
    e.id = step_id;
    sb.push_back(e);
    step_id++;
    if (!rst && (s == T_MEMWB || s == T_ALUWB || s == T_BEQ || s == T_ADDIWB ||
                 s == T_JMP || (s == T_MEMWR && rdy)))
      cnt_exp = cnt_exp + 32'd1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [18:0] got;
      e = sb.pop_front();
      got = {mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc, ALUSrcA,
             ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite, halted, illegal_op};
      n_checks++;
      if (got !== e.w) begin
        n_fail++;
        $display("FAIL ctrl_word step %0d: got %b want %b", e.id, got, e.w);
      end
      n_checks++;
      if (instr_retired !== e.c) begin
        n_fail++;
        $display("FAIL instr_retired step %0d: got %0d want %0d", e.id, instr_retired, e.c);
      end
    end
  end

  initial begin
    // Reset for 3 cycles with mem_ready high
    repeat (3) step(T_RST, RT, 1, 0, 1);
    // add: 4 cycles
    step(T_FETCH, RT, 1, 0, 0); step(T_DEC, RT, 1, 0, 0);
    step(T_EXEC, RT, 1, 0, 0);  step(T_ALUWB, RT, 1, 0, 0);
    // lw with 2 fetch waits and 1 read wait: 8 cycles
    step(T_FETCH, LW, 0, 0, 0); step(T_FETCH, LW, 0, 0, 0);
    step(T_FETCH, LW, 1, 0, 0); step(T_DEC, LW, 0, 0, 0);
    step(T_MEMADR, LW, 1, 0, 0); step(T_MEMRD, LW, 0, 0, 0);
    step(T_MEMRD, LW, 1, 0, 0); step(T_MEMWB, LW, 1, 0, 0);
    // sw, beq, j with zero-wait memory
    step(T_FETCH, SW, 1, 0, 0); step(T_DEC, SW, 1, 0, 0);
    step(T_MEMADR, SW, 1, 0, 0); step(T_MEMWR, SW, 1, 0, 0);
    step(T_FETCH, BQ, 1, 0, 0); step(T_DEC, BQ, 1, 0, 0); step(T_BEQ, BQ, 1, 0, 0);
    step(T_FETCH, JP, 1, 0, 0); step(T_DEC, JP, 1, 0, 0); step(T_JMP, JP, 1, 0, 0);
    // illegal opcode drops back to FETCH without retiring
    step(T_FETCH, BAD, 1, 0, 0); step(T_DECI, BAD, 1, 0, 0);
    // addi with a halt_req pulse that ends before the instruction end
    step(T_FETCH, AI, 1, 0, 0); step(T_DEC, AI, 1, 1, 0);
    step(T_ADDIEX, AI, 1, 0, 0); step(T_ADDIWB, AI, 0, 0, 0);
    // sw with a write wait; mem_ready ignored in DECODE/MEMADR
    step(T_FETCH, SW, 1, 0, 0); step(T_DEC, SW, 0, 0, 0);
    step(T_MEMADR, SW, 0, 0, 0); step(T_MEMWR, SW, 0, 0, 0);
    step(T_MEMWR, SW, 1, 0, 0);
    // R-type with halt raised in EXEC, then parked and released
    step(T_FETCH, RT, 1, 0, 0); step(T_DEC, RT, 1, 0, 0);
    step(T_EXEC, RT, 1, 1, 0);  step(T_ALUWB, RT, 1, 1, 0);
    repeat (5) step(T_HALT, RT, 1, 1, 0);
    step(T_HALT, RT, 1, 0, 0);
    step(T_FETCH, JP, 1, 0, 0); step(T_DEC, JP, 1, 0, 0); step(T_JMP, JP, 1, 0, 0);
    // reset during a stalled MEMRD abandons the load
    step(T_FETCH, LW, 1, 0, 0); step(T_DEC, LW, 1, 0, 0);
    step(T_MEMADR, LW, 1, 0, 0); step(T_MEMRD, LW, 0, 0, 0);
    step(T_RST, LW, 0, 0, 1);
    step(T_FETCH, LW, 0, 0, 0); step(T_FETCH, LW, 0, 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore-style main control FSM that sequences a multicycle MIPS datapath: fetch, decode, execute, memory and writeback.
- The datapath shares one unified instruction/data memory.
- The controller owns the memory request handshake, so memory may insert wait states.
- Also provides halt/run control and a retired-instruction counter for the processor testbench and debug.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- OP_W, 6, opcode field width (fixed to Instruction[31:26]; parameterised for the package only).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- opcode  in  6  Instruction[31:26] from the instruction register (valid from DECODE onward).
- mem_ready  in  1  memory completes current request this cycle.
- halt_req  in  1  level; stop at the next instruction boundary.
- mem_req  out  1  memory access request.
- IorD  out  1  0 = PC addresses memory, 1 = ALUOut.
- MemWrite  out  1  write strobe (qualified by mem_req).
- IRWrite  out  1  load instruction register.
- PCWrite  out  1  unconditional PC update.
- Branch  out  1  PC update if Zero.
- PCSrc  out  2  00 ALU, 01 ALUOut, 10 jump target.
- ALUSrcA  out  1  0 = PC, 1 = A register.
- ALUSrcB  out  2  00 B, 01 const 4, 10 signext, 11 signext<<2.
- ALUOp  out  2  00 add, 01 sub, 10 funct-decoded.
- RegDst  out  1  1 = rd, 0 = rt.
- MemtoReg  out  1  1 = MDR, 0 = ALUOut.
- RegWrite  out  1  register file write enable.
- halted  out  1  controller parked in HALT.
- illegal_op  out  1  one-cycle pulse on unknown opcode.
- instr_retired  out  CNT_W  count of completed instructions.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BEQ, ADDIEX, ADDIWB, JMP, HALT.
- Reset: state <= FETCH, instr_retired <= 0.
  - All outputs are 0 during any cycle with reset=1, including mem_req, strobes, selects, halted and illegal_op.
  - Reset mid-instruction abandons the instruction with no writes.
- FETCH:
  - Drives mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite and PCWrite are asserted only in the cycle where mem_ready=1; that is the only Mealy output pair.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target). Next state by opcode:
  - 000000 -> EXEC
  - 100011 / 101011 -> MEMADR
  - 000100 -> BEQ
  - 001000 -> ADDIEX
  - 000010 -> JMP
  - other -> FETCH with illegal_op=1 for that one cycle; not counted as retired.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_req=1, IorD=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1.
- MEMWR: mem_req=1, IorD=1, MemWrite=1. Holds until mem_ready, then ends the instruction.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Branch=1, PCSrc=01.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0.
- JMP: PCWrite=1, PCSrc=10.
- Instruction end (last cycle of MEMWB, MEMWR+ready, ALUWB, BEQ, ADDIWB, JMP):
  - instr_retired increments by 1, wrapping modulo 2^CNT_W.
  - Next state is HALT if halt_req=1, else FETCH.
- Cycle counts with zero-wait memory:
  - R-type 4, lw 5, sw 4, beq 3, addi 4, j 3.
  - Each mem_ready=0 cycle adds one cycle.
- HALT: halted=1, all other outputs 0. Returns to FETCH in the cycle after halt_req is seen low.
- halt_req rising mid-instruction has no effect until the instruction end.
- halt_req pulsing high then low before the end is ignored.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- A write strobe (RegWrite, MemWrite, PCWrite, IRWrite) is never asserted in two consecutive states of the same instruction, except PCWrite+IRWrite together in FETCH.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J.
  - ALUOp encodings.
  - ALUSrcB and PCSrc select encodings.
  - state enum typedef ctrl_state_t.
- One sub-module, mips_ctrl_outdec: purely combinational state(+mem_ready) -> control-word decode.
- The FSM next-state logic and the counter stay in the top module.

Test Plan:
- Reset held 3 cycles with halt_req=0, mem_ready=1, then opcode 000000 (add 0x00221820): states FETCH,DECODE,EXEC,ALUWB; RegWrite=1, RegDst=1 in cycle 4; instr_retired=1 after 4 cycles.
- lw (0x8C440190) with mem_ready low for 2 cycles in FETCH and 1 cycle in MEMRD: 8 cycles total; IRWrite exactly one pulse; MemtoReg=1 with RegWrite in MEMWB.
- sw then beq then j with zero-wait memory: 4+3+3=10 cycles. MemWrite=1 only in MEMWR with IorD=1. Branch=1 only in BEQ. PCSrc=10 with PCWrite in JMP. instr_retired=3.
- opcode 111111: illegal_op pulses 1 cycle in DECODE; next state FETCH; instr_retired unchanged; no RegWrite/MemWrite.
- halt_req raised during EXEC of an R-type: ALUWB still writes, then halted=1; outputs idle for 5 cycles with instr_retired unchanged; halt_req low -> FETCH next cycle.
- reset asserted during MEMRD with mem_ready=0: next cycle state FETCH, all outputs 0 while reset=1, no MEMWB write, instr_retired=0.
